flag_condition_unit: RTL and testbench
======================================

Name: flag_condition_unit

Overview:
- Consumes the N/Z/C/V status flags produced by the ALU flag generators.
- Holds them in a status register and answers condition-code queries (branch/predication) with a registered taken/not-taken result.
- Keeps a saturating count of negative arithmetic results.
- Sits between the ALU flag outputs and the control/branch logic.

Parameters:
CNT_W, 8, width of the negative-result event counter.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
flag_valid  input  1  ALU presents a flag update this cycle
flag_ready  output  1  unit accepts flag updates
n_in  input  1  negative flag from ALU
z_in  input  1  zero flag from ALU
c_in  input  1  carry flag from ALU
v_in  input  1  overflow flag from ALU
is_arithmetic  input  1  update came from an arithmetic op (1) or logic op (0)
cond_valid  input  1  condition query request
cond  input  4  condition code to evaluate
cond_ready  output  1  unit can accept a query
result_valid  output  1  one-cycle pulse: result is valid
cond_taken  output  1  evaluated condition outcome
flags  output  4  held flags {N,Z,C,V}
neg_count  output  CNT_W  saturating count of accepted negative arithmetic results
clear_counts  input  1  synchronous clear of neg_count (and sticky_v when enabled)
sticky_v  output  1  sticky overflow (see Optional Feature)

Behaviour:
- Reset (rst=1 at an edge):
  - flags=4'b0000, neg_count=0, result_valid=0, cond_taken=0, sticky_v=0.
  - FSM goes to EMPTY.
  - flag_ready=0 while rst is high.
- FSM states:
  - EMPTY: no flag update has been accepted since reset. cond_ready=0; queries are ignored and produce no result. An accepted update moves the FSM to LOADED.
  - LOADED: cond_ready=1. The FSM stays in LOADED until reset.
- Flag acceptance:
  - An update is accepted when flag_valid && flag_ready; flag_ready=1 whenever rst=0.
  - Z is always loaded from z_in.
  - If is_arithmetic=1, N, C and V are loaded from n_in, c_in and v_in.
  - If is_arithmetic=0, N, C and V are forced to 0, matching the flag-generator convention that logic ops never assert N/C/V.
  - The new flags value is visible on flags the cycle after acceptance.
- Query:
  - A query is accepted when cond_valid && cond_ready.
  - The next cycle, result_valid=1 and cond_taken holds the evaluation. Latency is 1 cycle; back-to-back queries each get a pulse.
  - result_valid is 0 in every cycle that does not follow an accepted query.
  - cond_taken holds its last value when result_valid=0.
- Simultaneous update and query in the same cycle: the query evaluates the flags held before that update (read-before-write).
- A query in the same cycle as the first update after reset is ignored, because cond_ready=0 in EMPTY.
- Condition encoding:
  - 0 EQ: Z; 1 NE: !Z
  - 2 CS: C; 3 CC: !C
  - 4 MI: N; 5 PL: !N
  - 6 VS: V; 7 VC: !V
  - 8 HI: C&!Z; 9 LS: !C|Z
  - A GE: N==V; B LT: N!=V
  - C GT: !Z&(N==V); D LE: Z|(N!=V)
  - E AL: 1; F NV: 0
- Counter:
  - neg_count increments by 1 on each accepted update with is_arithmetic=1 and n_in=1.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - clear_counts=1 sets neg_count to 0 at the edge. Clear has priority over a same-cycle increment.
- Reset mid-operation: a pending result is dropped (result_valid=0 on the following cycle) and all state returns to reset values.

Optional Feature:
- Macro: FLAG_STICKY_V_EN.
- Defined:
  - sticky_v is set on any accepted update with is_arithmetic=1 and v_in=1.
  - Once set, it stays set until clear_counts or rst.
  - clear_counts has priority over a same-cycle set.
- Undefined: sticky_v is constant 0 and no storage is instantiated.
- All other behaviour is identical with or without the macro.

Test Plan:
- Reset, then cond_valid=1 with cond=E while in EMPTY -> cond_ready=0, result_valid stays 0; flags=0000, neg_count=0.
- Update n=1,z=0,c=0,v=0, is_arithmetic=1, then query cond=4 (MI) -> flags=1000; next cycle result_valid=1, cond_taken=1. Query cond=5 (PL) -> cond_taken=0.
- Update n=1,z=1,c=1,v=1 with is_arithmetic=0 -> flags=0100. Query cond=0 (EQ) -> cond_taken=1; query cond=4 (MI) -> cond_taken=0.
- Same-cycle update (n=0,v=1, arithmetic) and query cond=B (LT), with prior flags N=1,V=0 -> cond_taken=1, using the old flags; flags=0001 the next cycle.
- CNT_W=2, five arithmetic negative updates -> neg_count reads 1,2,3,3,3. clear_counts together with a sixth negative update -> neg_count=0.
- With FLAG_STICKY_V_EN: arithmetic update v=1, then v=0 -> sticky_v stays 1; clear_counts -> sticky_v=0. Without the macro -> sticky_v=0 throughout.

Source files
------------

// File: rtl/flag_condition_unit.sv
`default_nettype none
// ============================================================================
// Module   : flag_condition_unit
// Purpose  : Holds the ALU N/Z/C/V status flags and answers condition-code
//            queries with a registered taken/not-taken result one cycle after
//            the query. Also keeps a saturating count of negative arithmetic
//            results.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            flag_valid/ready    - flag update handshake (n/z/c/v_in,
//                                  is_arithmetic)
//            cond_valid/ready    - condition query handshake (cond)
//            result_valid        - one-cycle pulse, cond_taken is valid
//            cond_taken          - condition outcome, held between pulses
//            flags               - held flags {N,Z,C,V}
//            neg_count           - saturating negative-result counter
//            clear_counts        - clears neg_count and sticky_v
//            sticky_v            - sticky overflow indicator
// Options  : FLAG_STICKY_V_EN    - when defined, sticky_v is a real sticky
//                                  register; otherwise it is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module flag_condition_unit #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flag_valid,
    output logic             flag_ready,
    input  logic             n_in,
    input  logic             z_in,
    input  logic             c_in,
    input  logic             v_in,
    input  logic             is_arithmetic,
    input  logic             cond_valid,
    input  logic [3:0]       cond,
    output logic             cond_ready,
    output logic             result_valid,
    output logic             cond_taken,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] neg_count,
    input  logic             clear_counts,
    output logic             sticky_v
);

    typedef enum logic [0:0] {
        ST_EMPTY  = 1'b0,
        ST_LOADED = 1'b1
    } state_t;

    state_t           r_state;
    logic [3:0]       r_flags;
    logic [CNT_W-1:0] r_neg_count;
    logic             r_result_valid;
    logic             r_cond_taken;

    logic             w_flag_accept;
    logic             w_query_accept;
    logic [3:0]       w_new_flags;
    logic             w_neg_inc;
    logic             w_cond_base;
    logic             w_cond_result;
    logic             w_n, w_z, w_c, w_v;

    assign flag_ready     = !rst;
    assign cond_ready     = (r_state == ST_LOADED);
    assign w_flag_accept  = flag_valid && flag_ready;
    assign w_query_accept = cond_valid && cond_ready;

    // Logic ops never assert N/C/V; only Z comes through unchanged.
    assign w_new_flags = is_arithmetic ? {n_in, z_in, c_in, v_in}
                                       : {1'b0, z_in, 2'b00};
    assign w_neg_inc   = w_flag_accept && is_arithmetic && n_in;

    // Queries always read the currently held flags, so a same-cycle update
    // is not visible to the query (read-before-write).
    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Condition codes come in complementary pairs: the odd code of each pair
    // is the inverse of the even one, so only eight base terms are needed.
    always_comb begin
        w_cond_base = 1'b0;
        case (cond[3:1])
            3'd0: w_cond_base = w_z;
            3'd1: w_cond_base = w_c;
            3'd2: w_cond_base = w_n;
            3'd3: w_cond_base = w_v;
            3'd4: w_cond_base = w_c && !w_z;
            3'd5: w_cond_base = (w_n == w_v);
            3'd6: w_cond_base = !w_z && (w_n == w_v);
            3'd7: w_cond_base = 1'b1;
            default: w_cond_base = 1'b0;
        endcase
    end
    assign w_cond_result = w_cond_base ^ cond[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_EMPTY;
            r_flags        <= 4'b0000;
            r_neg_count    <= '0;
            r_result_valid <= 1'b0;
            r_cond_taken   <= 1'b0;
        end else begin
            r_result_valid <= w_query_accept;
            if (w_query_accept) begin
                r_cond_taken <= w_cond_result;
            end

            case (r_state)
                ST_EMPTY: begin
                    if (w_flag_accept) begin
                        r_state <= ST_LOADED;
                    end
                end
                ST_LOADED: r_state <= ST_LOADED;
                default:   r_state <= ST_EMPTY;
            endcase

            if (w_flag_accept) begin
                r_flags <= w_new_flags;
            end

            // Clear wins over a same-cycle increment; increment saturates.
            if (clear_counts) begin
                r_neg_count <= '0;
            end else if (w_neg_inc && !(&r_neg_count)) begin
                r_neg_count <= r_neg_count + 1'b1;
            end
        end
    end

`ifdef FLAG_STICKY_V_EN
    logic r_sticky_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky_v <= 1'b0;
        end else if (clear_counts) begin
            r_sticky_v <= 1'b0;
        end else if (w_flag_accept && is_arithmetic && v_in) begin
            r_sticky_v <= 1'b1;
        end
    end

    assign sticky_v = r_sticky_v;
`else
    assign sticky_v = 1'b0;
`endif

    assign flags        = r_flags;
    assign neg_count    = r_neg_count;
    assign result_valid = r_result_valid;
    assign cond_taken   = r_cond_taken;

endmodule
`default_nettype wire

// File: tb/tb_flag_condition_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_flag_condition_unit
// Purpose  : Self-checking bench for flag_condition_unit. Expected query
//            results are queued when a query is driven and popped when the
//            result pulse is due.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flag_condition_unit;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             flag_valid;
    logic             flag_ready;
    logic             n_in, z_in, c_in, v_in;
    logic             is_arithmetic;
    logic             cond_valid;
    logic [3:0]       cond;
    logic             cond_ready;
    logic             result_valid;
    logic             cond_taken;
    logic [3:0]       flags;
    logic [CNT_W-1:0] neg_count;
    logic             clear_counts;
    logic             sticky_v;

    flag_condition_unit #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flag_valid   (flag_valid),
        .flag_ready   (flag_ready),
        .n_in         (n_in),
        .z_in         (z_in),
        .c_in         (c_in),
        .v_in         (v_in),
        .is_arithmetic(is_arithmetic),
        .cond_valid   (cond_valid),
        .cond         (cond),
        .cond_ready   (cond_ready),
        .result_valid (result_valid),
        .cond_taken   (cond_taken),
        .flags        (flags),
        .neg_count    (neg_count),
        .clear_counts (clear_counts),
        .sticky_v     (sticky_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [3:0]       m_flags  = 4'b0000;
    logic [CNT_W-1:0] m_cnt    = '0;
    logic             m_sticky = 1'b0;
    logic             m_loaded = 1'b0;
    logic             m_expect = 1'b0;
    logic             exp_taken = 1'b0;
    logic             q[$];

    function automatic logic cond_eval(input logic [3:0] cd, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cd)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one cycle of stimulus, predict its effect, then advance to #1
    // after the sampling edge.
    task automatic apply(input logic fv, input logic n, input logic z,
                         input logic c, input logic v, input logic ar,
                         input logic qv, input logic [3:0] cd,
                         input logic clr, input logic r);
        rst = r; flag_valid = fv; n_in = n; z_in = z; c_in = c; v_in = v;
        is_arithmetic = ar; cond_valid = qv; cond = cd; clear_counts = clr;
        m_expect = 1'b0;
        if (r) begin
            q.delete();
            m_flags = 4'b0000; m_cnt = '0; m_sticky = 1'b0;
            m_loaded = 1'b0; exp_taken = 1'b0;
        end else begin
            if (qv && m_loaded) begin
                q.push_back(cond_eval(cd, m_flags));
                m_expect = 1'b1;
            end
            if (fv) begin
                m_flags  = ar ? {n, z, c, v} : {1'b0, z, 2'b00};
                m_loaded = 1'b1;
                if (ar && n && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
`ifdef FLAG_STICKY_V_EN
                if (ar && v) m_sticky = 1'b1;
`endif
            end
            if (clr) begin
                m_cnt = '0;
                m_sticky = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    endtask

    task automatic test_reset();
        apply(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1);
        apply(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1);
        n_cmp++;
        if (flag_ready !== 1'b0) begin n_err++; $display("FAIL reset flag_ready: got %b want 0", flag_ready); end
        n_cmp++;
        if (flags !== 4'b0000 || neg_count !== '0 || result_valid !== 1'b0 ||
            cond_taken !== 1'b0 || sticky_v !== 1'b0) begin
            n_err++;
            $display("FAIL reset state: got flags=%b cnt=%0d rv=%b ct=%b sv=%b want all 0",
                     flags, neg_count, result_valid, cond_taken, sticky_v);
        end
        for (int i = 0; i < 2; i++) begin
            apply(0, 0, 0, 0, 0, 0, 1, 4'hE, 0, 0);
            n_cmp++;
            if (cond_ready !== 1'b0 || flag_ready !== 1'b1) begin
                n_err++;
                $display("FAIL empty ready: got cond_ready=%b flag_ready=%b want 0/1", cond_ready, flag_ready);
            end
            n_cmp++;
            if (result_valid !== 1'b0) begin n_err++; $display("FAIL empty query rv: got %b want 0", result_valid); end
        end
    endtask

    task automatic test_arith_update();
        logic [3:0] cds [3] = '{4'h4, 4'h5, 4'h0};
        logic       qvs [3] = '{1'b1, 1'b1, 1'b0};
        apply(1, 1, 0, 0, 0, 1, 0, 4'h0, 0, 0);
        n_cmp++;
        if (flags !== 4'b1000 || cond_ready !== 1'b1 || neg_count !== m_cnt) begin
            n_err++;
            $display("FAIL arith load: got flags=%b cr=%b cnt=%0d want 1000/1/%0d", flags, cond_ready, neg_count, m_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 0, 0, qvs[i], cds[i], 0, 0);
            n_cmp++;
            if (result_valid !== m_expect) begin n_err++; $display("FAIL arith rv step %0d: got %b want %b", i, result_valid, m_expect); end
            if (m_expect) exp_taken = q.pop_front();
            n_cmp++;
            if (cond_taken !== exp_taken) begin n_err++; $display("FAIL arith taken step %0d: got %b want %b", i, cond_taken, exp_taken); end
        end
    endtask

    task automatic test_logic_update();
        logic [3:0] cds [2] = '{4'h0, 4'h4};
        apply(1, 1, 1, 1, 1, 0, 0, 4'h0, 0, 0);
        n_cmp++;
        if (flags !== 4'b0100) begin n_err++; $display("FAIL logic load flags: got %b want 0100", flags); end
        for (int i = 0; i < 2; i++) begin
            apply(0, 0, 0, 0, 0, 0, 1, cds[i], 0, 0);
            n_cmp++;
            if (result_valid !== m_expect) begin n_err++; $display("FAIL logic rv step %0d: got %b want %b", i, result_valid, m_expect); end
            if (m_expect) exp_taken = q.pop_front();
            n_cmp++;
            if (cond_taken !== exp_taken) begin n_err++; $display("FAIL logic taken cond %0h: got %b want %b", cds[i], cond_taken, exp_taken); end
        end
    endtask

    task automatic test_same_cycle();
        apply(1, 1, 0, 0, 0, 1, 0, 4'h0, 0, 0);
        apply(1, 0, 0, 0, 1, 1, 1, 4'hB, 0, 0);
        n_cmp++;
        if (result_valid !== m_expect) begin n_err++; $display("FAIL same-cycle rv: got %b want %b", result_valid, m_expect); end
        if (m_expect) exp_taken = q.pop_front();
        n_cmp++;
        if (cond_taken !== exp_taken) begin n_err++; $display("FAIL same-cycle taken: got %b want %b", cond_taken, exp_taken); end
        n_cmp++;
        if (flags !== 4'b0001) begin n_err++; $display("FAIL same-cycle flags: got %b want 0001", flags); end
    endtask

    task automatic test_all_conds();
        logic [3:0] pats [5] = '{4'b0000, 4'b0101, 4'b1001, 4'b0110, 4'b1111};
        for (int p = 0; p < 5; p++) begin
            apply(1, pats[p][3], pats[p][2], pats[p][1], pats[p][0], 1, 0, 4'h0, 0, 0);
            // back-to-back queries over every code, then one idle cycle
            for (int k = 0; k < 17; k++) begin
                apply(0, 0, 0, 0, 0, 0, (k < 16), 4'(k), 0, 0);
                n_cmp++;
                if (result_valid !== m_expect) begin
                    n_err++;
                    $display("FAIL cond rv flags=%b step %0d: got %b want %b", pats[p], k, result_valid, m_expect);
                end
                if (m_expect) exp_taken = q.pop_front();
                n_cmp++;
                if (cond_taken !== exp_taken) begin
                    n_err++;
                    $display("FAIL cond taken flags=%b step %0d: got %b want %b", pats[p], k, cond_taken, exp_taken);
                end
            end
        end
    endtask

    task automatic test_counter();
        apply(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            apply(1, 1, 0, 0, 0, 1, 0, 4'h0, 0, 0);
            n_cmp++;
            if (neg_count !== m_cnt) begin n_err++; $display("FAIL counter step %0d: got %0d want %0d", i, neg_count, m_cnt); end
        end
        apply(1, 1, 0, 0, 0, 0, 0, 4'h0, 1, 0);
        apply(1, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0);
        n_cmp++;
        if (neg_count !== m_cnt) begin n_err++; $display("FAIL counter logic-op: got %0d want %0d", neg_count, m_cnt); end
        apply(1, 1, 0, 0, 0, 1, 0, 4'h0, 0, 0);
        apply(1, 1, 0, 0, 0, 1, 0, 4'h0, 1, 0);
        n_cmp++;
        if (neg_count !== '0) begin n_err++; $display("FAIL counter clear priority: got %0d want 0", neg_count); end
    endtask

    task automatic test_sticky();
        logic vs  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic clr [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            apply(1, 0, 0, 0, vs[i], 1, 0, 4'h0, clr[i], 0);
            n_cmp++;
            if (sticky_v !== m_sticky) begin n_err++; $display("FAIL sticky step %0d: got %b want %b", i, sticky_v, m_sticky); end
        end
    endtask

    task automatic test_reset_mid();
        apply(1, 1, 1, 1, 1, 1, 0, 4'h0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 1, 4'hE, 0, 1);
        n_cmp++;
        if (result_valid !== 1'b0 || flags !== 4'b0000 || neg_count !== '0 || cond_taken !== 1'b0) begin
            n_err++;
            $display("FAIL reset mid-op: got rv=%b flags=%b cnt=%0d ct=%b want 0/0000/0/0",
                     result_valid, flags, neg_count, cond_taken);
        end
        apply(0, 0, 0, 0, 0, 0, 1, 4'hE, 0, 0);
        n_cmp++;
        if (result_valid !== 1'b0 || cond_ready !== 1'b0) begin
            n_err++;
            $display("FAIL after reset query: got rv=%b cr=%b want 0/0", result_valid, cond_ready);
        end
    endtask

    initial begin
        rst = 1'b1; flag_valid = 1'b0; n_in = 1'b0; z_in = 1'b0; c_in = 1'b0;
        v_in = 1'b0; is_arithmetic = 1'b0; cond_valid = 1'b0; cond = 4'h0;
        clear_counts = 1'b0;
        test_reset();
        test_arith_update();
        test_logic_update();
        test_same_cycle();
        test_all_conds();
        test_counter();
        test_sticky();
        test_reset_mid();
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
